// File: rtl/id_hazard_scoreboard_pkg.sv
// rtl/id_hazard_scoreboard_pkg.sv - shared constants and entry layout for the ID hazard scoreboard
package id_hazard_scoreboard_pkg;

   localparam int REG_AW_DEF = 5;
   localparam int ZERO_REG   = 31;

   // Forwarding select encoding: 0 reads the regfile, k+1 takes stage k's result
   localparam int FWD_RF  = 0;
   localparam int FWD_EX  = 1;
   localparam int FWD_MEM = 2;
   localparam int FWD_WB  = 3;

   // One tracked in-flight instruction at the default register width
   typedef struct packed {
      logic                  v;
      logic [REG_AW_DEF-1:0] rd;
      logic                  ld;
   } entry_t;

endpackage

// File: rtl/id_hazard_scoreboard_if.sv
// rtl/id_hazard_scoreboard_if.sv - ID-stage operand bundle and hazard/forward results
interface id_hazard_scoreboard_if #(
   parameter int REG_AW = 5,
   parameter int FWD_W  = 2,
   parameter int CNT_W  = 16
);
   logic              id_valid;
   logic [REG_AW-1:0] id_ra;
   logic              id_ra_used;
   logic [REG_AW-1:0] id_rb;
   logic              id_rb_used;
   logic [REG_AW-1:0] id_rd;
   logic              id_rd_we;
   logic              id_is_load;
   logic              id_flush;
   logic              stall;
   logic              issue;
   logic [FWD_W-1:0]  fwd_a;
   logic [FWD_W-1:0]  fwd_b;
   logic [CNT_W-1:0]  stall_cnt;

   modport master (
      output id_valid, id_ra, id_ra_used, id_rb, id_rb_used,
             id_rd, id_rd_we, id_is_load, id_flush,
      input  stall, issue, fwd_a, fwd_b, stall_cnt
   );

   modport slave (
      input  id_valid, id_ra, id_ra_used, id_rb, id_rb_used,
             id_rd, id_rd_we, id_is_load, id_flush,
      output stall, issue, fwd_a, fwd_b, stall_cnt
   );
endinterface

// File: rtl/id_hazard_scoreboard_hazard_match_prio.sv
// rtl/id_hazard_scoreboard_hazard_match_prio.sv - match one source against all in-flight entries
module hazard_match_prio #(
   parameter int REG_AW     = 5,
   parameter int ZERO_REG   = 31,
   parameter int PIPE_DEPTH = 3,
   parameter int FWD_W      = 2
) (
   input  logic [REG_AW-1:0]                  src,
   input  logic                               used,
   input  logic [PIPE_DEPTH-1:0]              ent_v,
   input  logic [PIPE_DEPTH-1:0]              ent_ld,
   input  logic [PIPE_DEPTH-1:0][REG_AW-1:0]  ent_rd,
   output logic                               hit,
   output logic                               ld_at_ex,
   output logic [FWD_W-1:0]                   fwd_sel
);
   import id_hazard_scoreboard_pkg::*;

   logic [PIPE_DEPTH-1:0] match;

   // Per-entry match; the zero register never produces a hazard
   always_comb begin
      match = '0;
      for (int k = 0; k < PIPE_DEPTH; k++) begin
         match[k] = used && (src != REG_AW'(ZERO_REG)) && ent_v[k] && (ent_rd[k] == src);
      end
   end

   // Scan oldest to youngest so the youngest producer is the last one assigned
   always_comb begin
      hit      = |match;
      ld_at_ex = match[0] & ent_ld[0];
      fwd_sel  = FWD_W'(FWD_RF);
      for (int k = PIPE_DEPTH - 1; k >= 0; k--) begin
         if (match[k]) begin
            fwd_sel = FWD_W'(FWD_EX + k);
         end
      end
   end

endmodule

// File: rtl/id_hazard_scoreboard.sv
// rtl/id_hazard_scoreboard.sv - in-flight destination tracking, load-use stall and EX forwarding selects
module id_hazard_scoreboard #(
   parameter int REG_AW     = 5,
   parameter int ZERO_REG   = id_hazard_scoreboard_pkg::ZERO_REG,
   parameter int PIPE_DEPTH = 3,
   parameter int FWD_W      = $clog2(PIPE_DEPTH + 1),
   parameter int CNT_W      = 16
) (
   input logic                 clk,
   input logic                 rst_n,
   id_hazard_scoreboard_if.slave bus
);
   import id_hazard_scoreboard_pkg::*;

   logic [PIPE_DEPTH-1:0]             ent_v;
   logic [PIPE_DEPTH-1:0]             ent_ld;
   logic [PIPE_DEPTH-1:0][REG_AW-1:0] ent_rd;
   logic [CNT_W-1:0]                  cnt_q;

   logic hit_a, hit_b, ld_a, ld_b;
   logic [FWD_W-1:0] sel_a, sel_b;
   logic active, stall, issue;

   hazard_match_prio #(
      .REG_AW(REG_AW), .ZERO_REG(ZERO_REG), .PIPE_DEPTH(PIPE_DEPTH), .FWD_W(FWD_W)
   ) u_match_a (
      .src(bus.id_ra), .used(bus.id_ra_used),
      .ent_v(ent_v), .ent_ld(ent_ld), .ent_rd(ent_rd),
      .hit(hit_a), .ld_at_ex(ld_a), .fwd_sel(sel_a)
   );

   hazard_match_prio #(
      .REG_AW(REG_AW), .ZERO_REG(ZERO_REG), .PIPE_DEPTH(PIPE_DEPTH), .FWD_W(FWD_W)
   ) u_match_b (
      .src(bus.id_rb), .used(bus.id_rb_used),
      .ent_v(ent_v), .ent_ld(ent_ld), .ent_rd(ent_rd),
      .hit(hit_b), .ld_at_ex(ld_b), .fwd_sel(sel_b)
   );

   // Flush and reset both squash the ID instruction before any hazard is considered
   always_comb begin
      active = rst_n & bus.id_valid & ~bus.id_flush;
      stall  = active & (ld_a | ld_b);
      issue  = active & ~stall;
   end

   assign bus.stall     = stall;
   assign bus.issue     = issue;
   assign bus.fwd_a     = sel_a;
   assign bus.fwd_b     = sel_b;
   assign bus.stall_cnt = cnt_q;

   // Advance the in-flight window every cycle; non-issuing cycles inject a bubble
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ent_v  <= '0;
         ent_ld <= '0;
         for (int k = 0; k < PIPE_DEPTH; k++) begin
            ent_rd[k] <= REG_AW'(ZERO_REG);
         end
      end else begin
         ent_v  <= {ent_v[PIPE_DEPTH-2:0],
                    issue & bus.id_rd_we & (bus.id_rd != REG_AW'(ZERO_REG))};
         ent_ld <= {ent_ld[PIPE_DEPTH-2:0], issue & bus.id_is_load};
         ent_rd <= {ent_rd[PIPE_DEPTH-2:0], issue ? bus.id_rd : REG_AW'(ZERO_REG)};
      end
   end

   // Saturating count of stall cycles
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (stall && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// tb/tb_id_hazard_scoreboard.sv - queue-based scoreboard bench for id_hazard_scoreboard
module tb_id_hazard_scoreboard;

   typedef struct {
      int         id;
      logic       s;
      logic       i;
      logic [1:0] fa;
      logic [1:0] fb;
      logic       chk;
      logic [3:0] cnt;
   } exp_t;

   logic clk;
   logic rst_n;
   exp_t q[$];
   int   total;
   int   passed;
   int   vec_id;
   logic [3:0] model_cnt;

   id_hazard_scoreboard_if #(.REG_AW(5), .FWD_W(2), .CNT_W(4)) bus ();

   id_hazard_scoreboard #(
      .REG_AW(5), .ZERO_REG(31), .PIPE_DEPTH(3), .CNT_W(4)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input int id, input string nm, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL v%0d %s actual=%0d expected=%0d", id, nm, act, exp);
   endtask

   // Monitor: outputs are combinational, so each driven cycle is checked mid-cycle
   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         check(e.id, "stall", 16'(bus.stall), 16'(e.s));
         check(e.id, "issue", 16'(bus.issue), 16'(e.i));
         check(e.id, "stall_cnt", 16'(bus.stall_cnt), 16'(e.cnt));
         if (e.chk) begin
            check(e.id, "fwd_a", 16'(bus.fwd_a), 16'(e.fa));
            check(e.id, "fwd_b", 16'(bus.fwd_b), 16'(e.fb));
         end
      end
   end

   task automatic cyc(input logic r, input logic v,
                      input logic [4:0] ra, input logic rau,
                      input logic [4:0] rb, input logic rbu,
                      input logic [4:0] rd, input logic we, input logic ld, input logic fl,
                      input logic s, input logic i, input logic [1:0] fa, input logic [1:0] fb,
                      input logic chk);
      exp_t e;
      rst_n          = r;
      bus.id_valid   = v;
      bus.id_ra      = ra;
      bus.id_ra_used = rau;
      bus.id_rb      = rb;
      bus.id_rb_used = rbu;
      bus.id_rd      = rd;
      bus.id_rd_we   = we;
      bus.id_is_load = ld;
      bus.id_flush   = fl;
      e.id  = vec_id;
      e.s   = s;
      e.i   = i;
      e.fa  = fa;
      e.fb  = fb;
      e.chk = chk;
      e.cnt = model_cnt;
      q.push_back(e);
      vec_id++;
      @(posedge clk);
      #1;
      if (!r) model_cnt = 4'd0;
      else if (s && model_cnt != 4'd15) model_cnt = model_cnt + 4'd1;
   endtask

   initial begin
      total = 0; passed = 0; vec_id = 0; model_cnt = 4'd0;
      rst_n = 1'b0;
      bus.id_valid = 1'b1; bus.id_ra = 5'd3; bus.id_ra_used = 1'b1;
      bus.id_rb = 5'd3; bus.id_rb_used = 1'b1; bus.id_rd = 5'd3;
      bus.id_rd_we = 1'b1; bus.id_is_load = 1'b0; bus.id_flush = 1'b0;
      @(posedge clk);
      #1;

      // reset held with a valid instruction present
      cyc(0,1, 3,1, 3,1, 3,1,0,0,  0,0,0,0,1);
      cyc(0,1, 3,1, 3,1, 3,1,0,0,  0,0,0,0,1);

      // ALU producer x3 followed by readers at EX, MEM, WB, then retired
      cyc(1,1, 0,0, 0,0, 3,1,0,0,  0,1,0,0,1);
      cyc(1,1, 3,1, 0,0, 31,0,0,0, 0,1,1,0,1);
      cyc(1,1, 3,1, 0,0, 31,0,0,0, 0,1,2,0,1);
      cyc(1,1, 3,1, 0,0, 31,0,0,0, 0,1,3,0,1);
      cyc(1,1, 3,1, 0,0, 31,0,0,0, 0,1,0,0,1);

      // load-use on x5: one stall, then forward from MEM
      cyc(1,1, 0,0, 0,0, 5,1,1,0,  0,1,0,0,1);
      cyc(1,1, 0,0, 5,1, 31,0,0,0, 1,0,0,0,0);
      cyc(1,1, 0,0, 5,1, 31,0,0,0, 0,1,0,2,1);

      // two writers of x7: the youngest wins
      cyc(1,1, 0,0, 0,0, 7,1,0,0,  0,1,0,0,1);
      cyc(1,1, 0,0, 0,0, 31,0,0,0, 0,1,0,0,1);
      cyc(1,1, 7,1, 0,0, 7,1,0,0,  0,1,2,0,1);
      cyc(1,1, 7,1, 0,0, 31,0,0,0, 0,1,1,0,1);

      // writes and loads to the zero register are never tracked
      cyc(1,1, 0,0, 0,0, 31,1,0,0, 0,1,0,0,1);
      cyc(1,1, 31,1, 31,1, 31,0,0,0, 0,1,0,0,1);
      cyc(1,1, 0,0, 0,0, 31,1,1,0, 0,1,0,0,1);
      cyc(1,1, 31,1, 31,1, 31,0,0,0, 0,1,0,0,1);

      // flush beats a load-use hazard and leaves a bubble in EX
      cyc(1,1, 0,0, 0,0, 9,1,1,0,  0,1,0,0,1);
      cyc(1,1, 9,1, 0,0, 31,0,0,1, 0,0,0,0,0);
      cyc(1,1, 9,1, 0,0, 31,0,0,0, 0,1,2,0,1);

      // reset right after a stall clears the window and the counter
      cyc(1,1, 0,0, 0,0, 5,1,1,0,  0,1,0,0,1);
      cyc(1,1, 0,0, 5,1, 31,0,0,0, 1,0,0,0,0);
      cyc(0,1, 0,0, 5,1, 31,0,0,0, 0,0,0,0,0);
      cyc(1,1, 0,0, 5,1, 31,0,0,0, 0,1,0,0,1);

      // twenty load-use stalls drive the 4-bit counter into saturation
      for (int n = 0; n < 20; n++) begin
         cyc(1,1, 0,0, 0,0, 5,1,1,0,  0,1,0,0,1);
         cyc(1,1, 0,0, 5,1, 31,0,0,0, 1,0,0,0,0);
         cyc(1,1, 0,0, 5,1, 31,0,0,0, 0,1,0,2,1);
      end

      bus.id_valid = 1'b0;
      @(negedge clk);
      #1;
      total++;
      if (q.size() == 0) passed++;
      else $display("FAIL drain pending=%0d expected=0", q.size());

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/id_hazard_scoreboard.md
Name: id_hazard_scoreboard

Overview:
Parametrised successor to the decode-stage register selector. It tracks in-flight destination registers across PIPE_DEPTH post-decode stages, issuing a load-use stall and per-operand forwarding selects to the execute stage. It sits in ID, consumes the already-selected source and destination register addresses (ra/rb/rd plus used flags), and drives the pipeline stall and EX forwarding muxes. It also keeps a saturating stall-cycle performance counter.

Parameters:
REG_AW, 5, register address width
ZERO_REG, 31, hard-wired zero register index; never tracked, never forwarded
PIPE_DEPTH, 3, tracked stages after ID (0=EX, 1=MEM, 2=WB); minimum 2
FWD_W, $clog2(PIPE_DEPTH+1), forwarding select width
CNT_W, 16, stall counter width

Ports:
clk  in  1  clock
rst_n  in  1  synchronous reset, active low
id_valid  in  1  ID holds a real instruction
id_ra  in  REG_AW  source A address
id_ra_used  in  1  source A read
id_rb  in  REG_AW  source B address
id_rb_used  in  1  source B read
id_rd  in  REG_AW  destination address
id_rd_we  in  1  instruction writes rd
id_is_load  in  1  instruction is a load (result ready only after MEM)
id_flush  in  1  squash the ID instruction this cycle
stall  out  1  hold IF/ID; insert bubble into EX
issue  out  1  ID instruction enters EX this cycle
fwd_a  out  FWD_W  source A select: 0 = regfile, k+1 = stage k result
fwd_b  out  FWD_W  source B select, same encoding
stall_cnt  out  CNT_W  saturating count of stall cycles

Behaviour:
- Interface: one clock clk; reset rst_n is synchronous and active-low.
- State: PIPE_DEPTH entries {v, rd, ld}. Entry 0 = EX, entry PIPE_DEPTH-1 = oldest.
- Reset (rst_n=0 at posedge): all entry v=0, rd=ZERO_REG, ld=0, stall_cnt=0. Combinational outputs then read stall=0, issue=0, fwd_a=fwd_b=0.
- Match rule: source X matches entry k iff X_used, X!=ZERO_REG, entry k v=1, and entry k rd==X.
- stall = id_valid & ~id_flush & (source A or B matches entry 0 with ld=1). This is the load-use hazard. A load in entry >=1 forwards and does not stall.
- issue = id_valid & ~id_flush & ~stall.
- fwd_X selects the lowest matching k (youngest producer wins) and gives k+1. If nothing matches, fwd_X is 0. During a stall, fwd_X is still driven but don't-care.
- Every posedge (rst_n=1): entry k+1 <= entry k for all k, and entry PIPE_DEPTH-1 retires.
- Entry 0 on issue: {id_rd_we & (id_rd!=ZERO_REG), id_rd, id_is_load}. Otherwise entry 0 gets a bubble {0, ZERO_REG, 0}.
- stall_cnt increments on each cycle with stall=1 and holds at 2^CNT_W-1.
- Simultaneous id_flush and hazard: flush wins. stall=0, issue=0, bubble inserted.
- Same-cycle write and read in the retiring stage: regfile write-through is required externally, so no match beyond PIPE_DEPTH-1.
- Reset mid-stall: the next cycle has stall=0 and all entries are invalid.
- Outputs stall/issue/fwd are combinational from current state and ID inputs (zero latency). The scoreboard update has 1-cycle latency.

Decomposition:
- Shared package holds: ZERO_REG, the fwd encoding constants (FWD_RF=0, FWD_EX=1, FWD_MEM=2, FWD_WB=3), and the entry struct/field widths.
- One sub-module, hazard_match_prio: compares one source against all entries and outputs {hit, ld_at_ex, fwd_sel}. It is instantiated twice, for A and B.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with id_valid=1 -> stall=0, fwd_a=fwd_b=0, stall_cnt=0, all entries invalid.
- ALU back-to-back: issue writes x3 (not a load); next cycle ID reads ra=3 -> stall=0, fwd_a=1. One cycle later -> fwd_a=2. Then fwd_a=3. Then fwd_a=0.
- Load-use: issue load rd=5; next ID reads rb=5 -> stall=1 for exactly 1 cycle, stall_cnt=1. Next cycle stall=0, fwd_b=2, issue=1.
- Youngest wins and zero register: writes to x7 at entry 2 and entry 0, with ID ra=7 -> fwd_a=1. Write to x31 followed by a read of ra=31 -> fwd_a=0, no entry valid.
- Flush with hazard: load rd=9 in EX, ID reads ra=9 with id_flush=1 -> stall=0, issue=0. Next cycle entry 0 v=0.
- Counter saturation: with CNT_W=4, force 20 consecutive load-use stall cycles -> stall_cnt stops at 15.
